// File: rtl/cdb_slot_scheduler_if.sv
// Common data bus scheduler interface: requests and grants from the functional
// units, plus the registered view of which source owns the CDB each cycle.
interface cdb_slot_scheduler_if;
  logic       Req_Int0, Req_Int1, Req_LS;
  logic       Req_Mult, Req_Div;
  logic [4:0] Mult_Tag, Div_Tag;
  logic       Flush;
  logic       Grant_Int0, Grant_Int1, Grant_LS, Grant_Mult, Grant_Div;
  logic [2:0] CDB_Src;
  logic [4:0] CDB_Long_Tag;
  logic [3:0] Resv_Count;

  // Requester side: functional units and the flush source.
  modport master (
    output Req_Int0, Req_Int1, Req_LS, Req_Mult, Req_Div, Mult_Tag, Div_Tag, Flush,
    input  Grant_Int0, Grant_Int1, Grant_LS, Grant_Mult, Grant_Div,
    input  CDB_Src, CDB_Long_Tag, Resv_Count
  );

  // Scheduler side.
  modport slave (
    input  Req_Int0, Req_Int1, Req_LS, Req_Mult, Req_Div, Mult_Tag, Div_Tag, Flush,
    output Grant_Int0, Grant_Int1, Grant_LS, Grant_Mult, Grant_Div,
    output CDB_Src, CDB_Long_Tag, Resv_Count
  );
endinterface

// File: rtl/cdb_slot_scheduler.sv
// CDB slot scheduler. Long-latency units (Mult/Div) book their future CDB
// write slot at grant time in a shifting reservation vector; single-cycle
// units share whatever slots are left via a 3-way round-robin.
// Legal only for DIV_LAT > MULT_LAT >= 2.
module cdb_slot_scheduler #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input logic                Clk,
  input logic                Rst,
  cdb_slot_scheduler_if.slave bus
);
  typedef struct packed {
    logic       vld;
    logic [4:0] tag;
    logic       is_div;
  } resv_t;

  // resv[k] describes the CDB slot k cycles after the current one.
  resv_t [DIV_LAT-1:1] resv, resv_nxt;
  logic  [3:0]         cnt_nxt;
  logic  [1:0]         rr;
  logic  [2:0]         sc_req, sc_gnt;
  logic  [1:0]         sc_idx;
  logic                sc_any, sc_ok;
  logic  [2:0]         j;
  logic                gnt_mult, gnt_div;

  // Long-latency grants: Mult needs its slot free after the shift; the Div slot
  // is never targeted by anyone else so it only yields to flush/reset.
  assign gnt_mult = bus.Req_Mult & ~bus.Flush & ~Rst & ~resv[MULT_LAT].vld;
  assign gnt_div  = bus.Req_Div  & ~bus.Flush & ~Rst;

  assign sc_req = {bus.Req_LS, bus.Req_Int1, bus.Req_Int0};
  assign sc_ok  = ~bus.Flush & ~Rst & ~resv[1].vld;

  // Round-robin pick among single-cycle requesters, search starting at rr.
  always_comb begin
    sc_any = 1'b0;
    sc_idx = 2'd0;
    j      = 3'd0;
    for (int i = 0; i < 3; i++) begin
      j = {1'b0, rr} + 3'(i);
      if (j >= 3'd3) j = j - 3'd3;
      if (!sc_any && sc_ok && sc_req[j[1:0]]) begin
        sc_any = 1'b1;
        sc_idx = j[1:0];
      end
    end
    sc_gnt = sc_any ? (3'b001 << sc_idx) : 3'b000;
  end

  assign bus.Grant_Int0 = sc_gnt[0];
  assign bus.Grant_Int1 = sc_gnt[1];
  assign bus.Grant_LS   = sc_gnt[2];
  assign bus.Grant_Mult = gnt_mult;
  assign bus.Grant_Div  = gnt_div;

  // Next reservation vector: shift toward slot 1, then drop in new bookings.
  // The Mult target slot is known free here, so the overwrite loses nothing.
  always_comb begin
    resv_nxt = '0;
    for (int k = 1; k < DIV_LAT - 1; k++) resv_nxt[k] = resv[k+1];
    if (gnt_mult) resv_nxt[MULT_LAT-1] = '{vld: 1'b1, tag: bus.Mult_Tag, is_div: 1'b0};
    if (gnt_div)  resv_nxt[DIV_LAT-1]  = '{vld: 1'b1, tag: bus.Div_Tag,  is_div: 1'b1};
    if (bus.Flush) resv_nxt = '0;
    cnt_nxt = '0;
    for (int k = 1; k < DIV_LAT; k++) cnt_nxt = cnt_nxt + 4'(resv_nxt[k].vld);
  end

  // State and registered CDB ownership; a booked long-latency slot always wins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      resv             <= '0;
      rr               <= 2'd0;
      bus.CDB_Src      <= 3'd0;
      bus.CDB_Long_Tag <= 5'd0;
      bus.Resv_Count   <= 4'd0;
    end else begin
      resv           <= resv_nxt;
      bus.Resv_Count <= cnt_nxt;
      if (sc_any) rr <= (sc_idx == 2'd2) ? 2'd0 : sc_idx + 2'd1;
      if (bus.Flush) begin
        bus.CDB_Src      <= 3'd0;
        bus.CDB_Long_Tag <= 5'd0;
      end else if (resv[1].vld) begin
        bus.CDB_Src      <= resv[1].is_div ? 3'd5 : 3'd4;
        bus.CDB_Long_Tag <= resv[1].tag;
      end else if (sc_any) begin
        bus.CDB_Src      <= {1'b0, sc_idx} + 3'd1;
        bus.CDB_Long_Tag <= 5'd0;
      end else begin
        bus.CDB_Src      <= 3'd0;
        bus.CDB_Long_Tag <= 5'd0;
      end
    end
  end
endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed bench for the CDB slot scheduler (MULT_LAT=4, DIV_LAT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled before
// the next edge.
module tb_cdb_slot_scheduler;
  logic Clk, Rst;
  int   n_chk, n_fail;

  cdb_slot_scheduler_if bus ();
  cdb_slot_scheduler #(.MULT_LAT(4), .DIV_LAT(8)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.Req_Int0 = 0; bus.Req_Int1 = 0; bus.Req_LS = 0;
    bus.Req_Mult = 0; bus.Req_Div = 0; bus.Flush = 0;
    bus.Mult_Tag = 0; bus.Div_Tag = 0;
  endtask

  task automatic sc_grants(input string tag, input int g0, input int g1, input int gls);
    #1;
    chk({tag, "_g0"}, int'(bus.Grant_Int0), g0);
    chk({tag, "_g1"}, int'(bus.Grant_Int1), g1);
    chk({tag, "_gls"}, int'(bus.Grant_LS), gls);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    idle();
    Rst = 1;
    step();
    // Grants held low during reset even with requests present.
    bus.Req_Int0 = 1; bus.Req_Mult = 1; bus.Req_Div = 1;
    #1;
    chk("rst_gint0", int'(bus.Grant_Int0), 0);
    chk("rst_gmult", int'(bus.Grant_Mult), 0);
    chk("rst_gdiv",  int'(bus.Grant_Div), 0);
    chk("rst_src",   int'(bus.CDB_Src), 0);
    chk("rst_tag",   int'(bus.CDB_Long_Tag), 0);
    chk("rst_cnt",   int'(bus.Resv_Count), 0);
    idle();
    Rst = 0;
    step();

    // Round-robin over three persistent requesters.
    bus.Req_Int0 = 1; bus.Req_Int1 = 1; bus.Req_LS = 1;
    sc_grants("rr1", 1, 0, 0); step(); chk("rr1_src", int'(bus.CDB_Src), 1);
    sc_grants("rr2", 0, 1, 0); step(); chk("rr2_src", int'(bus.CDB_Src), 2);
    sc_grants("rr3", 0, 0, 1); step(); chk("rr3_src", int'(bus.CDB_Src), 3);
    sc_grants("rr4", 1, 0, 0); step(); chk("rr4_src", int'(bus.CDB_Src), 1);
    idle(); step();
    chk("rr_idle_src", int'(bus.CDB_Src), 0);

    // Mult booking blocks a single-cycle grant in its write slot.
    bus.Req_Mult = 1; bus.Mult_Tag = 5'd9;
    #1; chk("m9_grant", int'(bus.Grant_Mult), 1);
    step(); idle();
    chk("m9_cnt", int'(bus.Resv_Count), 1);
    step(); step();
    bus.Req_Int1 = 1;
    #1; chk("m9_blk_int1", int'(bus.Grant_Int1), 0);
    step();
    chk("m9_src", int'(bus.CDB_Src), 4);
    chk("m9_tag", int'(bus.CDB_Long_Tag), 9);
    chk("m9_cnt0", int'(bus.Resv_Count), 0);
    #1; chk("m9_int1_retry", int'(bus.Grant_Int1), 1);
    step(); idle();
    chk("m9_int1_src", int'(bus.CDB_Src), 2);
    chk("m9_int1_tag", int'(bus.CDB_Long_Tag), 0);

    // Back-to-back Mult bookings.
    bus.Req_Mult = 1; bus.Mult_Tag = 5'd3;
    #1; chk("mm_g3", int'(bus.Grant_Mult), 1);
    step(); bus.Mult_Tag = 5'd4;
    #1; chk("mm_g4", int'(bus.Grant_Mult), 1);
    step(); idle();
    chk("mm_cnt", int'(bus.Resv_Count), 2);
    step(); step();
    chk("mm_src3", int'(bus.CDB_Src), 4);
    chk("mm_tag3", int'(bus.CDB_Long_Tag), 3);
    step();
    chk("mm_src4", int'(bus.CDB_Src), 4);
    chk("mm_tag4", int'(bus.CDB_Long_Tag), 4);
    step();
    chk("mm_src0", int'(bus.CDB_Src), 0);

    // Div slot collides with a later Mult request.
    bus.Req_Div = 1; bus.Div_Tag = 5'd7;
    #1; chk("dv_grant", int'(bus.Grant_Div), 1);
    step(); idle();
    step(); step(); step();
    bus.Req_Mult = 1; bus.Mult_Tag = 5'd2;
    #1; chk("dv_mult_blk", int'(bus.Grant_Mult), 0);
    step(); idle();
    step(); step(); step();
    chk("dv_src", int'(bus.CDB_Src), 5);
    chk("dv_tag", int'(bus.CDB_Long_Tag), 7);
    step();

    // Flush squashes pending bookings and all grants.
    bus.Req_Mult = 1; bus.Mult_Tag = 5'd11;
    #1; chk("fl_mgrant", int'(bus.Grant_Mult), 1);
    step(); idle(); step();
    bus.Flush = 1; bus.Req_Int0 = 1; bus.Req_Mult = 1; bus.Req_Div = 1;
    #1;
    chk("fl_gint0", int'(bus.Grant_Int0), 0);
    chk("fl_gmult", int'(bus.Grant_Mult), 0);
    chk("fl_gdiv",  int'(bus.Grant_Div), 0);
    step(); idle();
    chk("fl_cnt", int'(bus.Resv_Count), 0);
    chk("fl_src", int'(bus.CDB_Src), 0);
    step();
    chk("fl_src_t4", int'(bus.CDB_Src), 0);

    // Asynchronous reset with three bookings pending.
    bus.Req_Mult = 1; bus.Mult_Tag = 5'd1; bus.Req_Div = 1; bus.Div_Tag = 5'd6;
    step(); bus.Req_Div = 0; bus.Mult_Tag = 5'd2;
    step(); idle();
    chk("ar_cnt3", int'(bus.Resv_Count), 3);
    Rst = 1;
    #1;
    chk("ar_src", int'(bus.CDB_Src), 0);
    chk("ar_tag", int'(bus.CDB_Long_Tag), 0);
    chk("ar_cnt", int'(bus.Resv_Count), 0);
    Rst = 0;
    step();
    bus.Req_Int1 = 1;
    sc_grants("ar_i1", 0, 1, 0);
    step(); idle();
    chk("ar_i1_src", int'(bus.CDB_Src), 2);
    bus.Req_Int0 = 1; bus.Req_Int1 = 1; bus.Req_LS = 1;
    sc_grants("ar_rr2", 0, 0, 1);
    step(); idle();
    chk("ar_booked_gone", int'(bus.CDB_Src), 3);

    // Reset returns the round-robin pointer to Int0.
    bus.Req_Int1 = 1;
    step(); idle();
    Rst = 1; #1; Rst = 0;
    step();
    bus.Req_Int0 = 1; bus.Req_Int1 = 1; bus.Req_LS = 1;
    sc_grants("rr_rst", 1, 0, 0);
    step(); idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_slot_scheduler.md
CDB_SLOT_SCHEDULER -- requirements
Module: cdb_slot_scheduler

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4: cycles from Mult grant to its CDB write slot.
REQ-002 SHALL have parameter DIV_LAT, default 8: cycles from Div grant to its CDB write slot; legal only when DIV_LAT > MULT_LAT >= 2.
REQ-003 SHALL have port Clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port Rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports Req_Int0, Req_Int1, Req_LS, each input, 1: single-cycle unit has a result ready.
REQ-006 SHALL have ports Req_Mult and Req_Div, each input, 1: long-latency unit requests dispatch.
REQ-007 SHALL have ports Mult_Tag and Div_Tag, each input, 5: ROB tag of the requesting long-latency op.
REQ-008 SHALL have port Flush, input, 1: branch-mispredict squash.
REQ-009 SHALL have ports Grant_Int0, Grant_Int1, Grant_LS, Grant_Mult, Grant_Div, each output, 1, combinational: request accepted this cycle.
REQ-010 SHALL have port CDB_Src, output, 3, registered: source driving the CDB this cycle; 0 none, 1 Int0, 2 Int1, 3 LS, 4 Mult, 5 Div.
REQ-011 SHALL have port CDB_Long_Tag, output, 5, registered: tag of the Mult/Div result on the CDB this cycle, else 0.
REQ-012 SHALL have port Resv_Count, output, 4, registered: number of reserved future slots.

Function
REQ-013 SHALL hold a reservation vector Resv[1..DIV_LAT-1], each entry with a valid bit, a 5-bit tag, and a 1-bit Mult/Div type; Resv[k] denotes the CDB slot k cycles after the current cycle.
REQ-014 SHALL shift every cycle: Resv[k-1] <= Resv[k] for k = 2..DIV_LAT-1; Resv[DIV_LAT-1] loads empty unless it is set by REQ-016.
REQ-015 SHALL assert Grant_Mult iff Req_Mult=1, Flush=0 and Resv[MULT_LAT] is invalid (Resv[MULT_LAT] read before the shift).
REQ-016 SHALL, on Grant_Mult, write {valid, Mult_Tag, Mult} into Resv[MULT_LAT-1]; on Grant_Div, write {valid, Div_Tag, Div} into Resv[DIV_LAT-1]. Both grants may occur in one cycle.
REQ-017 SHALL assert Grant_Div iff Req_Div=1 and Flush=0; the DIV_LAT slot is always free because no other grant targets it.
REQ-018 SHALL grant at most one of Int0/Int1/LS per cycle, and only when Flush=0 and Resv[1] is invalid.
REQ-019 SHALL choose among single-cycle requesters by round-robin with a 2-bit pointer RR (0 Int0, 1 Int1, 2 LS). Search order starts at RR. After a grant, RR <= (granted index + 1) mod 3. RR is unchanged with no grant.
REQ-020 SHALL register CDB_Src and CDB_Long_Tag each cycle as follows, in priority order:
- Resv[1] valid: Src = 4 or 5 by type; CDB_Long_Tag = Resv[1] tag.
- Else a single-cycle grant: Src = 1, 2 or 3; CDB_Long_Tag = 0.
- Else: Src = 0; CDB_Long_Tag = 0.
REQ-021 SHALL never drive two sources in the same cycle. A single-cycle request blocked by REQ-018 SHALL receive no grant and SHALL be retried by the requester.
REQ-022 SHALL, when Flush=1: force all grants to 0, clear every Resv valid bit at the edge, load CDB_Src = 0 and CDB_Long_Tag = 0, and leave RR unchanged.
REQ-023 SHALL compute Resv_Count as the popcount of valid Resv entries after the update; maximum value DIV_LAT-1.

Reset
REQ-024 SHALL, on Rst=1, immediately clear the following, including mid-operation with reservations pending:
- all Resv entries;
- CDB_Src = 0, CDB_Long_Tag = 0, Resv_Count = 0;
- RR = 0.
REQ-025 SHALL hold all grants at 0 while Rst=1.

Verification
REQ-026 Req_Int0=Req_Int1=Req_LS=1 held for 4 cycles after reset -> grants Int0, Int1, LS, Int0; CDB_Src one cycle later = 1, 2, 3, 1.
REQ-027 Req_Mult=1 with Mult_Tag=5'd9 at cycle t, then Req_Int1=1 at t+3 -> Grant_Mult at t; Grant_Int1=0 at t+3; CDB_Src=4 and CDB_Long_Tag=9 at t+4; Grant_Int1=1 at t+4.
REQ-028 Req_Mult=1 for two consecutive cycles with tags 3 and 4 -> both granted; CDB_Src=4 at t+4 (tag 3) and t+5 (tag 4).
REQ-029 Req_Div (tag 7) at t and Req_Mult (tag 2) at t+4 -> Grant_Mult=0 at t+4 (slot t+8 taken); CDB_Long_Tag=7 at t+8.
REQ-030 Mult granted at t, Flush=1 at t+2 -> Resv_Count=0 after t+2; CDB_Src=0 at t+4.
REQ-031 Rst pulsed while Resv_Count=3 -> all outputs 0 immediately; the next Req_Int1 alone is granted and RR becomes 2.
